sc_spil_dbuf: RTL

//  Multi-word TX/RX data buffer between the SPI Lite register block and sc_spi_engine.

---
 rtl/sc_spil_dbuf_if.sv | 38 +++
 rtl/sc_spil_dbuf.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sc_spil_dbuf_if.sv
// Bus between the SPI Lite register block and engine on one side and the
// TX/RX data buffer on the other. Clock and reset stay outside the interface.
interface sc_spil_dbuf_if #(
    parameter int DW = 32
);
    logic          CLR;
    logic          TX_WENB;
    logic [DW-1:0] TX_WDAT;
    logic [3:0]    TXDPT;
    logic          TX_OVF;
    logic          GO;
    logic          CSEXTEND_IN;
    logic          ENG_TXSTART;
    logic          ENG_CSEXTEND;
    logic [DW-1:0] ENG_TXDATA;
    logic          ENG_COMPLETE;
    logic [DW-1:0] ENG_RXDATA;
    logic          RX_RENB;
    logic [DW-1:0] RX_RDAT;
    logic [3:0]    RXDPT;
    logic          RX_OVF;
    logic          BUSY;
    logic          DONE;

    // Register block / engine side
    modport master (
        output CLR, TX_WENB, TX_WDAT, GO, CSEXTEND_IN, ENG_COMPLETE, ENG_RXDATA, RX_RENB,
        input  TXDPT, TX_OVF, ENG_TXSTART, ENG_CSEXTEND, ENG_TXDATA, RX_RDAT, RXDPT,
               RX_OVF, BUSY, DONE
    );

    // Buffer side
    modport slave (
        input  CLR, TX_WENB, TX_WDAT, GO, CSEXTEND_IN, ENG_COMPLETE, ENG_RXDATA, RX_RENB,
        output TXDPT, TX_OVF, ENG_TXSTART, ENG_CSEXTEND, ENG_TXDATA, RX_RDAT, RXDPT,
               RX_OVF, BUSY, DONE
    );
endinterface

// File: rtl/sc_spil_dbuf.sv
// Multi-word TX/RX buffer between the SPI Lite registers and sc_spi_engine.
// TX words are queued by register writes and streamed to the engine as one
// burst on GO; every word returned by the engine is queued in the RX FIFO.
module sc_spil_dbuf #(
    parameter int DEPTH = 4,
    parameter int DW    = 32
) (
    input  logic          SYSCLK,
    input  logic          SYSRSTB,
    sc_spil_dbuf_if.slave bus
);
    // Pointers are only as wide as needed; the storage is rounded up to a
    // power of two so any pointer value is a legal index, but only DEPTH
    // entries are ever used because the pointers wrap at DEPTH-1.
    localparam int            AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int            MEM_WORDS = 1 << AW;
    localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
    localparam logic [3:0]    FULL_CNT  = 4'(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

    state_t        state_reg, state_next;

    logic [DW-1:0] tx_mem [0:MEM_WORDS-1];
    logic [DW-1:0] rx_mem [0:MEM_WORDS-1];

    logic [AW-1:0] tx_wr_reg, tx_rd_reg, rx_wr_reg, rx_rd_reg;
    logic [3:0]    tx_cnt_reg, rx_cnt_reg;
    logic          tx_ovf_reg, rx_ovf_reg;
    logic          done_reg, csx_reg, eng_csx_reg;
    logic [DW-1:0] eng_data_reg;

    logic          tx_pop, tx_push_ok, tx_push_drop;
    logic          rx_push, rx_pop, rx_push_ok, rx_push_drop;
    logic          done_next, csx_sel;
    logic [3:0]    tx_remaining;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // A push into a full FIFO still succeeds when the head leaves in the same
    // cycle. CLR suppresses every push and pop in its cycle.
    assign rx_pop       = bus.RX_RENB && (rx_cnt_reg != 4'd0) && !bus.CLR;
    assign tx_push_ok   = bus.TX_WENB && !bus.CLR && ((tx_cnt_reg != FULL_CNT) || tx_pop);
    assign tx_push_drop = bus.TX_WENB && !bus.CLR && (tx_cnt_reg == FULL_CNT) && !tx_pop;
    assign rx_push_ok   = rx_push && ((rx_cnt_reg != FULL_CNT) || rx_pop);
    assign rx_push_drop = rx_push && (rx_cnt_reg == FULL_CNT) && !rx_pop;

    // Words left behind the one being popped, counting a word that arrives
    // in the same cycle since it will join the burst.
    assign tx_remaining = tx_cnt_reg - 4'd1 + {3'b000, tx_push_ok};

    // Burst sequencing: next state, FIFO pop/push strobes and DONE request
    always_comb begin
        state_next = state_reg;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        done_next  = 1'b0;
        csx_sel    = csx_reg;
        case (state_reg)
            IDLE: begin
                if (bus.GO && (tx_cnt_reg != 4'd0)) begin
                    tx_pop     = 1'b1;
                    csx_sel    = bus.CSEXTEND_IN;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (bus.ENG_COMPLETE) begin
                    rx_push = 1'b1;
                    if (tx_cnt_reg != 4'd0) begin
                        tx_pop     = 1'b1;
                        state_next = LAUNCH;
                    end else begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (bus.CLR) begin
            state_next = IDLE;
            tx_pop     = 1'b0;
            rx_push    = 1'b0;
            done_next  = 1'b0;
        end
    end

    // TX storage write port (no reset: occupancy decides what is valid)
    always_ff @(posedge SYSCLK) begin
        if (tx_push_ok) tx_mem[tx_wr_reg] <= bus.TX_WDAT;
    end

    // RX storage write port
    always_ff @(posedge SYSCLK) begin
        if (rx_push_ok) rx_mem[rx_wr_reg] <= bus.ENG_RXDATA;
    end

    // TX FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB || bus.CLR) begin
            tx_wr_reg  <= '0;
            tx_rd_reg  <= '0;
            tx_cnt_reg <= 4'd0;
            tx_ovf_reg <= 1'b0;
        end else begin
            tx_ovf_reg <= tx_push_drop;
            if (tx_push_ok) tx_wr_reg <= ptr_inc(tx_wr_reg);
            if (tx_pop)     tx_rd_reg <= ptr_inc(tx_rd_reg);
            if (tx_push_ok && !tx_pop)      tx_cnt_reg <= tx_cnt_reg + 4'd1;
            else if (!tx_push_ok && tx_pop) tx_cnt_reg <= tx_cnt_reg - 4'd1;
        end
    end

    // RX FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB || bus.CLR) begin
            rx_wr_reg  <= '0;
            rx_rd_reg  <= '0;
            rx_cnt_reg <= 4'd0;
            rx_ovf_reg <= 1'b0;
        end else begin
            rx_ovf_reg <= rx_push_drop;
            if (rx_push_ok) rx_wr_reg <= ptr_inc(rx_wr_reg);
            if (rx_pop)     rx_rd_reg <= ptr_inc(rx_rd_reg);
            if (rx_push_ok && !rx_pop)      rx_cnt_reg <= rx_cnt_reg + 4'd1;
            else if (!rx_push_ok && rx_pop) rx_cnt_reg <= rx_cnt_reg - 4'd1;
        end
    end

    // FSM state plus the engine word/CS-hold registers loaded on every pop
    always_ff @(posedge SYSCLK) begin
        if (!SYSRSTB) begin
            state_reg    <= IDLE;
            done_reg     <= 1'b0;
            csx_reg      <= 1'b0;
            eng_csx_reg  <= 1'b0;
            eng_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (bus.CLR) begin
                eng_csx_reg <= 1'b0;
            end else if (tx_pop) begin
                eng_data_reg <= tx_mem[tx_rd_reg];
                csx_reg      <= csx_sel;
                eng_csx_reg  <= csx_sel && (tx_remaining != 4'd0);
            end else if (done_next) begin
                eng_csx_reg <= 1'b0;
            end
        end
    end

    assign bus.TXDPT        = tx_cnt_reg;
    assign bus.TX_OVF       = tx_ovf_reg;
    assign bus.RXDPT        = rx_cnt_reg;
    assign bus.RX_OVF       = rx_ovf_reg;
    assign bus.RX_RDAT      = (rx_cnt_reg != 4'd0) ? rx_mem[rx_rd_reg] : '0;
    assign bus.ENG_TXSTART  = (state_reg == LAUNCH);
    assign bus.ENG_CSEXTEND = eng_csx_reg;
    assign bus.ENG_TXDATA   = eng_data_reg;
    assign bus.BUSY         = (state_reg != IDLE);
    assign bus.DONE         = done_reg;
endmodule
